csr_hpm_counters: RTL

Parametrised bank of RISC-V hardware performance monitor counters (mhpmcounter3.., mhpmevent3.., mcountinhibit) for the CSR unit. It generalises the fixed mcycle/minstret pair to NUM_CNT event-selectable counters of CNT_WIDTH bits, split into low/high 32-bit CSR halves. It sits beside the existing CSR file, shares its access port, and receives one-cycle event pulses from the pipeline.

---
 rtl/csr_hpm_counters_pkg.sv | 43 ++++
 rtl/csr_hpm_counters_hpm_counter.sv | 102 ++++++++++
 rtl/csr_hpm_counters.sv | 137 +++++++++++++
 3 files changed

// File: rtl/csr_hpm_counters_pkg.sv
// Shared CSR definitions for the hardware performance monitor bank: access ops,
// CSR addresses, event index names, bank defaults and the read-modify-write merge.
package csr_hpm_counters_pkg;

    localparam int HPM_NUM_CNT = 4;
    localparam int HPM_NUM_EVT = 16;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'd0,
        CSR_OP_RW   = 2'd1,
        CSR_OP_RS   = 2'd2,
        CSR_OP_RC   = 2'd3
    } csr_op_t;

    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT = 12'h320,
        CSR_MHPMEVENT3    = 12'h323,
        CSR_MHPMCOUNTER3  = 12'hB03,
        CSR_MHPMCOUNTER3H = 12'hB83
    } csr_addr_t;

    typedef enum logic [7:0] {
        HPM_EVT_ICACHE_MISS = 8'd0,
        HPM_EVT_DCACHE_MISS = 8'd1,
        HPM_EVT_BR_MISPRED  = 8'd2,
        HPM_EVT_STALL       = 8'd3
    } hpm_evt_t;

    // Callers zero-extend operands into 64 bits and cast the result back to the field width.
    function automatic logic [63:0] csr_merge(input csr_op_t op,
                                              input logic [63:0] old_v,
                                              input logic [63:0] wdata);
        logic [63:0] res;
        case (op)
            CSR_OP_RW: res = wdata;
            CSR_OP_RS: res = old_v | wdata;
            CSR_OP_RC: res = old_v & ~wdata;
            default:   res = old_v;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_hpm_counters_hpm_counter.sv
// One performance counter channel: event selector, counter, increment and CSR write merge.
// The sticky overflow flag exists only when HPM_OVF_EN is defined.
module hpm_counter
    import csr_hpm_counters_pkg::*;
#(
    parameter int CNT_WIDTH = 64,
    parameter int NUM_EVT   = 16,
    parameter int SEL_W     = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_EVT-1:0]   i_evt,
    input  logic                 i_inhibit,
    input  logic                 i_evt_we,
    input  logic                 i_lo_we,
    input  logic                 i_hi_we,
    input  csr_op_t              i_op,
    input  logic [31:0]          i_wdata,
    output logic [31:0]          o_evt_rd,
    output logic [31:0]          o_lo_rd,
    output logic [31:0]          o_hi_rd
`ifdef HPM_OVF_EN
    ,
    output logic                 o_ovf
`endif
);

    localparam int HI_W = CNT_WIDTH - 32;

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [SEL_W-1:0]     r_sel;
    logic                 w_evt_hit;
    logic                 w_inc;
    logic [31:0]          w_lo_new;
    logic [HI_W-1:0]      w_hi_new;
    logic [SEL_W-1:0]     w_sel_new;

    // Selectors above NUM_EVT match no input and therefore never count.
    always_comb begin
        w_evt_hit = 1'b0;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (r_sel == SEL_W'(k + 1) && i_evt[k]) begin
                w_evt_hit = 1'b1;
            end
        end
    end

    assign w_inc     = w_evt_hit && !i_inhibit;
    assign w_lo_new  = 32'(csr_merge(i_op, 64'(r_cnt[31:0]), 64'(i_wdata)));
    assign w_hi_new  = HI_W'(csr_merge(i_op, 64'(r_cnt[CNT_WIDTH-1:32]), 64'(i_wdata)));
    assign w_sel_new = SEL_W'(csr_merge(i_op, 64'(r_sel), 64'(i_wdata)));

    // A write to either half suppresses the increment for the whole counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_lo_we) begin
            r_cnt[31:0] <= w_lo_new;
        end else if (i_hi_we) begin
            r_cnt[CNT_WIDTH-1:32] <= w_hi_new;
        end else if (w_inc) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel <= '0;
        end else if (i_evt_we) begin
            r_sel <= w_sel_new;
        end
    end

    assign o_lo_rd = r_cnt[31:0];
    assign o_hi_rd = 32'(r_cnt[CNT_WIDTH-1:32]);

`ifdef HPM_OVF_EN
    logic r_ovf;
    logic w_wrap;
    logic w_ovf_new;

    assign w_wrap    = w_inc && (&r_cnt) && !i_lo_we && !i_hi_we;
    assign w_ovf_new = 1'(csr_merge(i_op, 64'(r_ovf), 64'(i_wdata[31])));

    // A wrap on the same edge as a clearing write keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_wrap) begin
            r_ovf <= 1'b1;
        end else if (i_evt_we) begin
            r_ovf <= w_ovf_new;
        end
    end

    assign o_ovf    = r_ovf;
    assign o_evt_rd = {r_ovf, 31'(r_sel)};
`else
    assign o_evt_rd = 32'(r_sel);
`endif

endmodule

// File: rtl/csr_hpm_counters.sv
// Bank of NUM_CNT event-selectable performance counters with mcountinhibit, CSR decode
// and read mux. Overflow flags and interrupt are built only when HPM_OVF_EN is defined.
module csr_hpm_counters
    import csr_hpm_counters_pkg::*;
#(
    parameter int NUM_CNT   = HPM_NUM_CNT,
    parameter int CNT_WIDTH = 64,
    parameter int NUM_EVT   = HPM_NUM_EVT,
    parameter int SEL_W     = $clog2(NUM_EVT + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_EVT-1:0] i_evt,
    input  logic               i_csr_en,
    input  logic [11:0]        i_csr_addr,
    input  csr_op_t            i_csr_op,
    input  logic [31:0]        i_csr_wdata,
    output logic               o_csr_hit,
    output logic [31:0]        o_csr_rdata
`ifdef HPM_OVF_EN
    ,
    output logic [NUM_CNT-1:0] o_ovf,
    output logic               o_ovf_irq
`endif
);

    localparam logic [11:0] A_INH    = CSR_MCOUNTINHIBIT;
    localparam logic [11:0] A_EVT    = CSR_MHPMEVENT3;
    localparam logic [11:0] A_CNT_LO = CSR_MHPMCOUNTER3;
    localparam logic [11:0] A_CNT_HI = CSR_MHPMCOUNTER3H;

    logic [NUM_CNT-1:0] r_inhibit;
    logic               w_we;
    logic               w_inh_we;
    logic [NUM_CNT-1:0] w_inh_new;
    logic [31:0]        w_inh_rd;
    logic [NUM_CNT-1:0] w_evt_we;
    logic [NUM_CNT-1:0] w_lo_we;
    logic [NUM_CNT-1:0] w_hi_we;
    logic [31:0]        w_evt_rd [NUM_CNT];
    logic [31:0]        w_lo_rd  [NUM_CNT];
    logic [31:0]        w_hi_rd  [NUM_CNT];
    logic               w_hit;
    logic [31:0]        w_rdata;

    assign w_we      = i_csr_en && (i_csr_op != CSR_OP_NONE);
    assign w_inh_rd  = 32'({r_inhibit, 3'b000});
    assign w_inh_new = NUM_CNT'(csr_merge(i_csr_op, 64'(r_inhibit),
                                          64'(i_csr_wdata[NUM_CNT+2:3])));

    always_comb begin
        w_hit    = 1'b0;
        w_rdata  = '0;
        w_inh_we = 1'b0;
        w_evt_we = '0;
        w_lo_we  = '0;
        w_hi_we  = '0;
        if (i_csr_addr == A_INH) begin
            w_hit    = 1'b1;
            w_rdata  = w_inh_rd;
            w_inh_we = w_we;
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            if (i_csr_addr == A_EVT + 12'(i)) begin
                w_hit       = 1'b1;
                w_rdata     = w_evt_rd[i];
                w_evt_we[i] = w_we;
            end
            if (i_csr_addr == A_CNT_LO + 12'(i)) begin
                w_hit      = 1'b1;
                w_rdata    = w_lo_rd[i];
                w_lo_we[i] = w_we;
            end
            if (i_csr_addr == A_CNT_HI + 12'(i)) begin
                w_hit      = 1'b1;
                w_rdata    = w_hi_rd[i];
                w_hi_we[i] = w_we;
            end
        end
    end

    assign o_csr_hit   = w_hit;
    assign o_csr_rdata = w_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inhibit <= '0;
        end else if (w_inh_we) begin
            r_inhibit <= w_inh_new;
        end
    end

`ifdef HPM_OVF_EN
    logic [NUM_CNT-1:0] w_ovf;
    logic               r_ovf_irq;
`endif

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        hpm_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .NUM_EVT   (NUM_EVT),
            .SEL_W     (SEL_W)
        ) u_cnt (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_evt     (i_evt),
            .i_inhibit (r_inhibit[g]),
            .i_evt_we  (w_evt_we[g]),
            .i_lo_we   (w_lo_we[g]),
            .i_hi_we   (w_hi_we[g]),
            .i_op      (i_csr_op),
            .i_wdata   (i_csr_wdata),
            .o_evt_rd  (w_evt_rd[g]),
            .o_lo_rd   (w_lo_rd[g]),
            .o_hi_rd   (w_hi_rd[g])
`ifdef HPM_OVF_EN
            ,
            .o_ovf     (w_ovf[g])
`endif
        );
    end

`ifdef HPM_OVF_EN
    // The interrupt follows the flags by one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf_irq <= 1'b0;
        end else begin
            r_ovf_irq <= |(w_ovf & ~r_inhibit);
        end
    end

    assign o_ovf     = w_ovf;
    assign o_ovf_irq = r_ovf_irq;
`endif

endmodule
